// File: rtl/reg_trace_rules_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_trace_rules_if
// Brief    : Register bus between the USB register front-end and the
//            trace-rule register block.
// Revision : 1.0
// ============================================================================
interface reg_trace_rules_if #(
    parameter int pBYTECNT_SIZE = 7
);
    logic [7:0]               reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic [7:0]               write_data;
    logic [7:0]               read_data;
    logic                     reg_read;
    logic                     reg_write;
    logic                     reg_addrvalid;
    logic                     selected;

    modport master (
        output reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
        input  read_data, selected
    );

    modport slave (
        input  reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
        output read_data, selected
    );
endinterface
`default_nettype wire

// File: rtl/reg_trace_rules.sv
`default_nettype none
// ============================================================================
// Module   : reg_trace_rules
// Brief    : Indexed shadow/live register block for trace match rules with a
//            one-rule-per-cycle commit engine and coherent counter snapshots.
// Revision : 1.0
// ============================================================================
module reg_trace_rules #(
    parameter int         pBYTECNT_SIZE = 7,
    parameter int         pBUFFER_SIZE  = 64,
    parameter int         pMATCH_RULES  = 16,
    parameter int         pCOUNT_WIDTH  = 8,
    parameter logic [1:0] pREG_SELECT   = 2'b10
) (
    input  wire logic                                   usb_clk,
    input  wire logic                                   reset_i,
    reg_trace_rules_if.slave                            bus,
    input  wire logic [pMATCH_RULES*pCOUNT_WIDTH-1:0]   I_trace_count,
    output logic      [pMATCH_RULES*pBUFFER_SIZE-1:0]   O_trace_pattern,
    output logic      [pMATCH_RULES*pBUFFER_SIZE-1:0]   O_trace_mask,
    output logic      [pMATCH_RULES-1:0]                O_pattern_enable,
    output logic      [pMATCH_RULES-1:0]                O_pattern_trig_enable,
    output logic                                        O_rules_update,
    output logic                                        O_reset_sync
);
    localparam int c_PAT_BYTES = pBUFFER_SIZE / 8;
    localparam int c_EN_BYTES  = (pMATCH_RULES + 7) / 8;
    localparam int c_CNT_BYTES = pCOUNT_WIDTH / 8;

    localparam logic [5:0] c_A_NAME  = 6'h00;
    localparam logic [5:0] c_A_REV   = 6'h01;
    localparam logic [5:0] c_A_IDX   = 6'h02;
    localparam logic [5:0] c_A_PAT   = 6'h03;
    localparam logic [5:0] c_A_MASK  = 6'h04;
    localparam logic [5:0] c_A_EN    = 6'h05;
    localparam logic [5:0] c_A_TEN   = 6'h06;
    localparam logic [5:0] c_A_CMT   = 6'h07;
    localparam logic [5:0] c_A_COUNT = 6'h08;
    localparam logic [5:0] c_A_RSYNC = 6'h09;

    localparam logic [63:0] c_NAME = "RuleTrce";
    localparam logic [7:0]  c_REV  = 8'h02;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COPY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [pBUFFER_SIZE-1:0] r_sh_pat  [pMATCH_RULES];
    logic [pBUFFER_SIZE-1:0] r_sh_mask [pMATCH_RULES];
    logic [pMATCH_RULES-1:0] r_sh_en;
    logic [pMATCH_RULES-1:0] r_sh_ten;
    logic [4:0]              r_idx;
    logic [4:0]              r_k;
    logic [pCOUNT_WIDTH-1:0] r_snap;
    state_t                  r_state;
    logic                    r_busy;
    logic                    r_dropped;
    logic                    r_rs_prev;

    logic                    w_sel, w_wr, w_rd, w_idx_ok, w_shadow_wr, w_bc_zero, w_rs;
    logic [5:0]              w_reg;
    logic [31:0]             w_bc;
    logic [pBUFFER_SIZE-1:0] w_pat_sel, w_mask_sel;
    logic [pCOUNT_WIDTH-1:0] w_cnt_sel;
    logic [8*c_EN_BYTES-1:0] w_en_pad, w_ten_pad;
    logic [7:0]              w_rdata;

    assign w_sel        = bus.reg_addrvalid && (bus.reg_address[7:6] == pREG_SELECT);
    assign bus.selected = w_sel;
    assign w_reg        = bus.reg_address[5:0];
    assign w_wr         = w_sel && bus.reg_write;
    assign w_rd         = w_sel && bus.reg_read;
    assign w_bc         = 32'(bus.reg_bytecnt);
    assign w_bc_zero    = (bus.reg_bytecnt == '0);
    assign w_idx_ok     = ({1'b0, r_idx} < 6'(pMATCH_RULES));
    assign w_shadow_wr  = w_wr && (w_reg inside {c_A_PAT, c_A_MASK, c_A_EN, c_A_TEN});
    assign w_rs         = w_wr && (w_reg == c_A_RSYNC);

    always_comb begin
        w_pat_sel  = '0;
        w_mask_sel = '0;
        w_cnt_sel  = '0;
        for (int r = 0; r < pMATCH_RULES; r++) begin
            if (r_idx == 5'(r)) begin
                w_pat_sel  = r_sh_pat[r];
                w_mask_sel = r_sh_mask[r];
                w_cnt_sel  = I_trace_count[r*pCOUNT_WIDTH +: pCOUNT_WIDTH];
            end
        end
        w_en_pad                     = '0;
        w_en_pad[pMATCH_RULES-1:0]   = r_sh_en;
        w_ten_pad                    = '0;
        w_ten_pad[pMATCH_RULES-1:0]  = r_sh_ten;
    end

    // Byte lanes past a register's width fall through to the zero default.
    always_comb begin
        w_rdata = 8'h00;
        case (w_reg)
            c_A_NAME:
                for (int b = 0; b < 8; b++)
                    if (w_bc == 32'(b)) w_rdata = c_NAME[8*(7-b) +: 8];
            c_A_REV:  if (w_bc_zero) w_rdata = c_REV;
            c_A_IDX:  if (w_bc_zero) w_rdata = {3'b000, r_idx};
            c_A_PAT, c_A_MASK:
                if (w_idx_ok)
                    for (int b = 0; b < c_PAT_BYTES; b++)
                        if (w_bc == 32'(b))
                            w_rdata = (w_reg == c_A_PAT) ? w_pat_sel[8*b +: 8] : w_mask_sel[8*b +: 8];
            c_A_EN, c_A_TEN:
                for (int b = 0; b < c_EN_BYTES; b++)
                    if (w_bc == 32'(b))
                        w_rdata = (w_reg == c_A_EN) ? w_en_pad[8*b +: 8] : w_ten_pad[8*b +: 8];
            c_A_CMT:  if (w_bc_zero) w_rdata = {6'b000000, r_dropped, r_busy};
            c_A_COUNT:
                if (w_idx_ok)
                    for (int b = 0; b < c_CNT_BYTES; b++)
                        if (w_bc == 32'(b))
                            w_rdata = (b == 0) ? w_cnt_sel[7:0] : r_snap[8*b +: 8];
            default:  w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            for (int r = 0; r < pMATCH_RULES; r++) begin
                r_sh_pat[r]  <= '0;
                r_sh_mask[r] <= '1;
            end
            r_sh_en       <= '0;
            r_sh_ten      <= '0;
            r_idx         <= '0;
            r_snap        <= '0;
            r_dropped     <= 1'b0;
            r_rs_prev     <= 1'b0;
            O_reset_sync  <= 1'b0;
            bus.read_data <= 8'h00;
        end else begin
            bus.read_data <= w_rd ? w_rdata : 8'h00;
            if (w_wr && (w_reg == c_A_IDX) && w_bc_zero)
                r_idx <= bus.write_data[4:0];
            if (w_shadow_wr && !r_busy) begin
                for (int r = 0; r < pMATCH_RULES; r++)
                    for (int b = 0; b < c_PAT_BYTES; b++)
                        if ((r_idx == 5'(r)) && (w_bc == 32'(b))) begin
                            if (w_reg == c_A_PAT)  r_sh_pat[r][8*b +: 8]  <= bus.write_data;
                            if (w_reg == c_A_MASK) r_sh_mask[r][8*b +: 8] <= bus.write_data;
                        end
                for (int j = 0; j < pMATCH_RULES; j++)
                    if (w_bc == 32'(j / 8)) begin
                        if (w_reg == c_A_EN)  r_sh_en[j]  <= bus.write_data[j % 8];
                        if (w_reg == c_A_TEN) r_sh_ten[j] <= bus.write_data[j % 8];
                    end
            end
            // A new drop wins over the clear-on-read of the status register.
            if (w_shadow_wr && r_busy)
                r_dropped <= 1'b1;
            else if (w_rd && (w_reg == c_A_CMT))
                r_dropped <= 1'b0;
            if (w_rd && (w_reg == c_A_COUNT) && w_bc_zero && w_idx_ok)
                r_snap <= w_cnt_sel;
            r_rs_prev    <= w_rs;
            O_reset_sync <= w_rs && !r_rs_prev;
        end
    end

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            r_state               <= S_IDLE;
            r_k                   <= '0;
            r_busy                <= 1'b0;
            O_rules_update        <= 1'b0;
            O_trace_pattern       <= '0;
            O_trace_mask          <= '1;
            O_pattern_enable      <= '0;
            O_pattern_trig_enable <= '0;
        end else begin
            O_rules_update <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_wr && (w_reg == c_A_CMT)) begin
                        r_busy  <= 1'b1;
                        r_k     <= '0;
                        r_state <= S_COPY;
                    end
                end
                S_COPY: begin
                    for (int r = 0; r < pMATCH_RULES; r++)
                        if (r_k == 5'(r)) begin
                            O_trace_pattern[r*pBUFFER_SIZE +: pBUFFER_SIZE] <= r_sh_pat[r];
                            O_trace_mask[r*pBUFFER_SIZE +: pBUFFER_SIZE]    <= r_sh_mask[r];
                            O_pattern_enable[r]                             <= r_sh_en[r];
                            O_pattern_trig_enable[r]                        <= r_sh_ten[r];
                        end
                    if (r_k == 5'(pMATCH_RULES - 1)) begin
                        O_rules_update <= 1'b1;
                        r_state        <= S_DONE;
                    end else begin
                        r_k <= r_k + 5'd1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_reg_trace_rules.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_trace_rules
// Brief    : Self-checking bench for reg_trace_rules against a rule-level model.
// Revision : 1.0
// ============================================================================
module tb_reg_trace_rules;
    localparam int R  = 16;
    localparam int W  = 64;
    localparam int CW = 16;

    localparam logic [5:0] A_NAME = 6'h00, A_REV = 6'h01, A_IDX = 6'h02, A_PAT = 6'h03,
                           A_MASK = 6'h04, A_EN = 6'h05, A_TEN = 6'h06, A_CMT = 6'h07,
                           A_COUNT = 6'h08, A_RSYNC = 6'h09;

    logic            usb_clk = 1'b0;
    logic            reset_i = 1'b1;
    logic [R*CW-1:0] cnt = '0;
    logic [R*W-1:0]  pat, mask;
    logic [R-1:0]    en, ten;
    logic            upd, rsync;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_sh_pat [R];
    logic [W-1:0] m_sh_mask[R];
    logic [W-1:0] m_lv_pat [R];
    logic [W-1:0] m_lv_mask[R];
    logic [R-1:0] m_sh_en, m_sh_ten, m_lv_en, m_lv_ten;

    reg_trace_rules_if #(.pBYTECNT_SIZE(7)) bus ();

    reg_trace_rules #(
        .pBYTECNT_SIZE(7), .pBUFFER_SIZE(W), .pMATCH_RULES(R),
        .pCOUNT_WIDTH(CW), .pREG_SELECT(2'b10)
    ) dut (
        .usb_clk(usb_clk), .reset_i(reset_i), .bus(bus), .I_trace_count(cnt),
        .O_trace_pattern(pat), .O_trace_mask(mask), .O_pattern_enable(en),
        .O_pattern_trig_enable(ten), .O_rules_update(upd), .O_reset_sync(rsync)
    );

    always #5 usb_clk = ~usb_clk;

    function automatic void model_reset();
        for (int r = 0; r < R; r++) begin
            m_sh_pat[r] = '0; m_sh_mask[r] = '1; m_lv_pat[r] = '0; m_lv_mask[r] = '1;
        end
        m_sh_en = '0; m_sh_ten = '0; m_lv_en = '0; m_lv_ten = '0;
    endfunction

    function automatic void model_commit();
        for (int r = 0; r < R; r++) begin
            m_lv_pat[r] = m_sh_pat[r]; m_lv_mask[r] = m_sh_mask[r];
        end
        m_lv_en = m_sh_en; m_lv_ten = m_sh_ten;
    endfunction

    function automatic logic [R*W-1:0] flat_pat();
        logic [R*W-1:0] f;
        for (int r = 0; r < R; r++) f[r*W +: W] = m_lv_pat[r];
        return f;
    endfunction

    function automatic logic [R*W-1:0] flat_mask();
        logic [R*W-1:0] f;
        for (int r = 0; r < R; r++) f[r*W +: W] = m_lv_mask[r];
        return f;
    endfunction

    task automatic bus_write(input logic [5:0] a, input int bc, input logic [7:0] d);
        bus.reg_address = {2'b10, a}; bus.reg_bytecnt = 7'(bc); bus.write_data = d;
        bus.reg_addrvalid = 1'b1; bus.reg_write = 1'b1;
        @(posedge usb_clk); #1;
        bus.reg_write = 1'b0; bus.reg_addrvalid = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, input int bc, output logic [7:0] d);
        bus.reg_address = {2'b10, a}; bus.reg_bytecnt = 7'(bc);
        bus.reg_addrvalid = 1'b1; bus.reg_read = 1'b1;
        @(posedge usb_clk); #1;
        d = bus.read_data;
        bus.reg_read = 1'b0; bus.reg_addrvalid = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the COMMIT write edge.
    task automatic wait_pulse(output int cyc);
        cyc = 1;
        while (upd !== 1'b1 && cyc < 60) begin
            @(posedge usb_clk); #1; cyc++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset_i = 1'b1;
        repeat (3) @(posedge usb_clk);
        #1 reset_i = 1'b0;
        model_reset();
        checks++; if (pat !== '0) begin errors++; $display("FAIL reset_pattern got %h want 0", pat); end
        checks++; if (mask !== '1) begin errors++; $display("FAIL reset_mask got %h want all ones", mask); end
        checks++; if ({en, ten} !== '0) begin errors++; $display("FAIL reset_enables got %h want 0", {en, ten}); end
        checks++; if ({upd, rsync} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {upd, rsync}); end
        checks++; if (bus.read_data !== 8'h00) begin errors++; $display("FAIL reset_read_data got %h want 00", bus.read_data); end
        bus_read(A_CMT, 0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", d); end
        bus_read(A_IDX, 0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_index got %h want 00", d); end
    endtask

    task automatic test_id();
        string      s = "RuleTrce";
        logic [7:0] d, e;
        for (int b = 0; b < 9; b++) begin
            bus_read(A_NAME, b, d);
            e = (b < 8) ? s[b] : 8'h00;
            checks++; if (d !== e) begin errors++; $display("FAIL name_byte%0d got %h want %h", b, d, e); end
        end
        bus_read(A_REV, 0, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL rev got %h want 02", d); end
        bus_read(A_REV, 1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rev_byte1 got %h want 00", d); end
        bus_read(6'h0A, 0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped_read got %h want 00", d); end
        bus.reg_address = 8'h41; bus.reg_bytecnt = '0; bus.reg_addrvalid = 1'b1; bus.reg_read = 1'b1;
        #1;
        checks++; if (bus.selected !== 1'b0) begin errors++; $display("FAIL selected_other got %b want 0", bus.selected); end
        @(posedge usb_clk); #1;
        checks++; if (bus.read_data !== 8'h00) begin errors++; $display("FAIL unselected_read got %h want 00", bus.read_data); end
        bus.reg_address = 8'h81; #1;
        checks++; if (bus.selected !== 1'b1) begin errors++; $display("FAIL selected_self got %b want 1", bus.selected); end
        bus.reg_read = 1'b0; bus.reg_addrvalid = 1'b0;
    endtask

    task automatic test_shadow_rw();
        logic [7:0] d, e;
        int r, b, sel;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, R-1); b = $urandom_range(0, 7); sel = $urandom_range(0, 1);
            d = 8'($urandom);
            bus_write(A_IDX, 0, 8'(r));
            bus_write(sel ? A_MASK : A_PAT, b, d);
            if (sel != 0) m_sh_mask[r][8*b +: 8] = d; else m_sh_pat[r][8*b +: 8] = d;
            r = $urandom_range(0, R-1); b = $urandom_range(0, 7); sel = $urandom_range(0, 1);
            bus_write(A_IDX, 0, 8'(r));
            bus_read(sel ? A_MASK : A_PAT, b, d);
            e = sel ? m_sh_mask[r][8*b +: 8] : m_sh_pat[r][8*b +: 8];
            checks++; if (d !== e) begin errors++; $display("FAIL shadow_rd r%0d b%0d sel%0d got %h want %h", r, b, sel, d, e); end
        end
        for (int b2 = 0; b2 < 3; b2++) begin
            d = 8'($urandom); bus_write(A_EN, b2, d);
            if (b2 < 2) m_sh_en[8*b2 +: 8] = d;
            d = 8'($urandom); bus_write(A_TEN, b2, d);
            if (b2 < 2) m_sh_ten[8*b2 +: 8] = d;
        end
        for (int b2 = 0; b2 < 3; b2++) begin
            bus_read(A_EN, b2, d);
            e = (b2 < 2) ? m_sh_en[8*b2 +: 8] : 8'h00;
            checks++; if (d !== e) begin errors++; $display("FAIL en_rd b%0d got %h want %h", b2, d, e); end
            bus_read(A_TEN, b2, d);
            e = (b2 < 2) ? m_sh_ten[8*b2 +: 8] : 8'h00;
            checks++; if (d !== e) begin errors++; $display("FAIL ten_rd b%0d got %h want %h", b2, d, e); end
        end
        checks++; if ({pat, mask, en, ten} !== {flat_pat(), flat_mask(), m_lv_en, m_lv_ten}) begin
            errors++; $display("FAIL live_before_commit got pat0 %h mask0 %h want pat0 %h mask0 %h", pat[W-1:0], mask[W-1:0], m_lv_pat[0], m_lv_mask[0]);
        end
    endtask

    task automatic test_commit();
        logic [7:0] d;
        int cyc;
        bus_write(A_IDX, 0, 8'd3);
        for (int b = 0; b < 8; b++) begin
            bus_write(A_PAT, b, 8'(17 * (b + 1)));
            m_sh_pat[3][8*b +: 8] = 8'(17 * (b + 1));
        end
        for (int b = 0; b < 8; b++) begin
            bus_read(A_PAT, b, d);
            checks++; if (d !== 8'(17 * (b + 1))) begin errors++; $display("FAIL pat3_readback b%0d got %h want %h", b, d, 8'(17 * (b + 1))); end
        end
        checks++; if (pat !== flat_pat()) begin errors++; $display("FAIL pat3_live_early got %h want %h", pat[3*W +: W], m_lv_pat[3]); end
        bus_write(A_CMT, 0, 8'h01);
        wait_pulse(cyc);
        checks++; if (cyc !== R + 1) begin errors++; $display("FAIL commit_latency got %0d want %0d", cyc, R + 1); end
        model_commit();
        checks++; if (pat[3*W +: W] !== 64'h8877665544332211) begin errors++; $display("FAIL pat3_live got %h want 8877665544332211", pat[3*W +: W]); end
        checks++; if ({pat, mask, en, ten} !== {flat_pat(), flat_mask(), m_lv_en, m_lv_ten}) begin
            errors++; $display("FAIL live_after_commit got en %h ten %h want en %h ten %h", en, ten, m_lv_en, m_lv_ten);
        end
        @(posedge usb_clk); #1;
        checks++; if (upd !== 1'b0) begin errors++; $display("FAIL update_width got %b want 0", upd); end
    endtask

    task automatic test_busy_drop();
        logic [7:0] d;
        int cyc;
        bus_write(A_IDX, 0, 8'd0);
        bus_write(A_CMT, 0, 8'h01);
        bus_write(A_MASK, 0, 8'h00);
        bus_read(A_CMT, 0, d);
        checks++; if (d !== 8'h03) begin errors++; $display("FAIL status_dropped got %h want 03", d); end
        bus_read(A_CMT, 0, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL status_cleared got %h want 01", d); end
        bus_write(A_CMT, 0, 8'h01);
        cyc = 0;
        while (upd !== 1'b1 && cyc < 40) begin @(posedge usb_clk); #1; cyc++; end
        checks++; if (upd !== 1'b1) begin errors++; $display("FAIL busy_commit_pulse got %b want 1", upd); end
        model_commit();
        checks++; if (mask !== flat_mask()) begin errors++; $display("FAIL drop_mask0 got %h want %h", mask[W-1:0], m_lv_mask[0]); end
        repeat (25) begin
            @(posedge usb_clk); #1;
            checks++; if (upd !== 1'b0) begin errors++; $display("FAIL ignored_commit_pulse got %b want 0", upd); end
        end
        bus_read(A_CMT, 0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL status_idle got %h want 00", d); end
    endtask

    task automatic test_range();
        logic [7:0] d, e;
        cnt = {R{16'hA5C3}};
        bus_write(A_IDX, 0, 8'd20);
        bus_read(A_IDX, 0, d);
        checks++; if (d !== 8'd20) begin errors++; $display("FAIL idx20 got %h want 14", d); end
        bus_write(A_PAT, 0, 8'hAA);
        bus_write(A_MASK, 0, 8'h55);
        bus_read(A_PAT, 0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL oor_pat got %h want 00", d); end
        bus_read(A_COUNT, 0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL oor_count0 got %h want 00", d); end
        bus_read(A_COUNT, 1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL oor_count1 got %h want 00", d); end
        bus_write(A_IDX, 0, 8'd0);
        bus_write(A_PAT, 8, 8'hEE);
        bus_read(A_PAT, 8, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL pat_byte8 got %h want 00", d); end
        for (int r = 0; r < R; r++)
            for (int b = 0; b < 8; b++) begin
                bus_write(A_IDX, 0, 8'(r));
                bus_read(A_PAT, b, d);
                e = m_sh_pat[r][8*b +: 8];
                if (d !== e) begin
                    checks++; errors++; $display("FAIL oor_side_effect r%0d b%0d got %h want %h", r, b, d, e);
                end
                bus_read(A_MASK, b, d);
                e = m_sh_mask[r][8*b +: 8];
                checks++; if (d !== e) begin errors++; $display("FAIL oor_mask_side_effect r%0d b%0d got %h want %h", r, b, d, e); end
            end
    endtask

    task automatic test_count();
        logic [7:0]  d;
        logic [15:0] v0, v1;
        int r;
        for (int i = 0; i < 6; i++) begin
            r  = (i == 0) ? 5 : $urandom_range(0, R-1);
            v0 = (i == 0) ? 16'h00FF : 16'($urandom);
            v1 = (i == 0) ? 16'h0100 : 16'($urandom);
            cnt[r*CW +: CW] = v0;
            bus_write(A_IDX, 0, 8'(r));
            bus_read(A_COUNT, 0, d);
            checks++; if (d !== v0[7:0]) begin errors++; $display("FAIL count_b0 r%0d got %h want %h", r, d, v0[7:0]); end
            cnt[r*CW +: CW] = v1;
            bus_read(A_COUNT, 1, d);
            checks++; if (d !== v0[15:8]) begin errors++; $display("FAIL count_b1_snapshot r%0d got %h want %h", r, d, v0[15:8]); end
            bus_read(A_COUNT, 2, d);
            checks++; if (d !== 8'h00) begin errors++; $display("FAIL count_b2 r%0d got %h want 00", r, d); end
            bus_read(A_COUNT, 0, d);
            checks++; if (d !== v1[7:0]) begin errors++; $display("FAIL count_b0_live r%0d got %h want %h", r, d, v1[7:0]); end
        end
    endtask

    task automatic test_reset_sync();
        int pulses;
        logic first;
        bus.reg_address = {2'b10, A_RSYNC}; bus.reg_bytecnt = '0; bus.write_data = 8'h01;
        bus.reg_addrvalid = 1'b1; bus.reg_write = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge usb_clk); #1;
            if (c == 0) first = rsync;
            pulses += int'(rsync);
        end
        bus.reg_write = 1'b0; bus.reg_addrvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin @(posedge usb_clk); #1; pulses += int'(rsync); end
        checks++; if (first !== 1'b1) begin errors++; $display("FAIL rsync_first got %b want 1", first); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL rsync_held_pulses got %0d want 1", pulses); end
        bus_write(A_RSYNC, 0, 8'h01);
        checks++; if (rsync !== 1'b1) begin errors++; $display("FAIL rsync_rearm got %b want 1", rsync); end
        @(posedge usb_clk); #1;
        checks++; if (rsync !== 1'b0) begin errors++; $display("FAIL rsync_width got %b want 0", rsync); end
    endtask

    task automatic test_reset_mid_commit();
        logic [7:0] d;
        int pulses, cyc;
        for (int r = 0; r < R; r++) begin
            bus_write(A_IDX, 0, 8'(r));
            bus_write(A_MASK, 0, 8'(r));
            m_sh_mask[r][7:0] = 8'(r);
        end
        bus_write(A_CMT, 0, 8'h01);
        repeat (5) begin @(posedge usb_clk); #1; end
        checks++; if (mask[W-1:0] !== m_sh_mask[0]) begin errors++; $display("FAIL mid_copy_mask0 got %h want %h", mask[W-1:0], m_sh_mask[0]); end
        reset_i = 1'b1;
        @(posedge usb_clk); #1;
        reset_i = 1'b0;
        model_reset();
        checks++; if ({pat, mask} !== {flat_pat(), flat_mask()}) begin errors++; $display("FAIL abort_live got mask0 %h want %h", mask[W-1:0], m_lv_mask[0]); end
        pulses = 0;
        for (int c = 0; c < 25; c++) begin @(posedge usb_clk); #1; pulses += int'(upd); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_pulses got %0d want 0", pulses); end
        bus_read(A_CMT, 0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL abort_status got %h want 00", d); end
        bus_write(A_CMT, 0, 8'h01);
        wait_pulse(cyc);
        checks++; if (cyc !== R + 1) begin errors++; $display("FAIL recommit_latency got %0d want %0d", cyc, R + 1); end
        model_commit();
        checks++; if ({pat, mask, en, ten} !== {flat_pat(), flat_mask(), m_lv_en, m_lv_ten}) begin
            errors++; $display("FAIL recommit_live got mask0 %h want %h", mask[W-1:0], m_lv_mask[0]);
        end
    endtask

    initial begin
        bus.reg_address = '0; bus.reg_bytecnt = '0; bus.write_data = '0;
        bus.reg_read = 1'b0; bus.reg_write = 1'b0; bus.reg_addrvalid = 1'b0;
        test_reset();
        test_id();
        test_shadow_rw();
        test_commit();
        test_busy_drop();
        test_range();
        test_count();
        test_reset_sync();
        test_reset_mid_commit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
